// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
//   Receive-path byte buffer between the MAC receiver and the USB-side
//   packetizer. Each entry holds {error, start, data}. The oldest entry is
//   presented first-word-fall-through on rd_data/rd_start/rd_error, which
//   read as zero while the buffer is empty. Writes while full are dropped
//   and the receiver is back-pressured through `full`.
//
//   Parameters:
//     DEPTH   number of entries (power of two, >= 4)
//     ADDR_W  pointer width, derived from DEPTH
//
//   Ports:
//     clk, n_rst                  clock, asynchronous active-low reset
//     wr_en, wr_start, wr_error,
//     wr_data[7:0]                write side (MAC receiver)
//     full                        buffer holds DEPTH entries
//     rd_en                       pop strobe from the consumer
//     rd_data[7:0], rd_start,
//     rd_error                    head entry (zero while empty)
//     empty                       buffer holds no entries
//     count[ADDR_W:0]             occupancy, 0..DEPTH
//     ovf, ovf_clr                sticky overflow flag and its clear;
//                                 present only when RX_FIFO_OVF_FLAG_EN
//                                 is defined
module rx_byte_fifo #(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic              wr_start,
  input  logic              wr_error,
  input  logic [7:0]        wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_start,
  output logic              rd_error,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef RX_FIFO_OVF_FLAG_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic [9:0]        head;

  // Acceptance is qualified by the registered flags, so a simultaneous
  // write+read on an empty buffer only writes, and on a full one only reads.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= {wr_error, wr_start, wr_data};
    end
  end

  // Pointers, occupancy and flags; full/empty are registered from the
  // next count so they line up with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ADDR_W'(1);
      if (rd_acc) rptr <= rptr + ADDR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  // Fall-through head: stale memory is masked while empty.
  always_comb begin
    head     = mem[rptr];
    rd_data  = 8'h00;
    rd_start = 1'b0;
    rd_error = 1'b0;
    if (!empty) begin
      rd_data  = head[7:0];
      rd_start = head[8];
      rd_error = head[9];
    end
  end

`ifdef RX_FIFO_OVF_FLAG_EN
  // Sticky overflow: a dropped write on the same edge as a clear wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en, wr_start, wr_error;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_start, rd_error, empty;
  logic [6:0] count;
`ifdef RX_FIFO_OVF_FLAG_EN
  logic       ovf, ovf_clr;
  bit         m_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference: a queue of {error, start, data} entries.
  logic [9:0] q[$];

  bit         last_pop_vld;
  logic [7:0] last_pop;
  bit         saw_full;

  always #5 clk = ~clk;

  rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (wr_en),
    .wr_start (wr_start),
    .wr_error (wr_error),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_start (rd_start),
    .rd_error (rd_error),
    .empty    (empty),
    .count    (count)
`ifdef RX_FIFO_OVF_FLAG_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h000;
    chk("m_count", 32'(count), q.size());
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full",  32'(full),  32'(q.size() == DEPTH));
    chk("m_data",  32'(rd_data),  32'(h[7:0]));
    chk("m_start", 32'(rd_start), 32'(h[8]));
    chk("m_error", 32'(rd_error), 32'(h[9]));
`ifdef RX_FIFO_OVF_FLAG_EN
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // Apply one cycle of inputs, advance the reference at the edge, then
  // compare all outputs 1 ns after the edge.
  task automatic step(input logic we, input logic ws, input logic wer,
                      input logic [7:0] wd, input logic re, input logic oc);
    bit wa, ra;
    wr_en = we; wr_start = ws; wr_error = wer; wr_data = wd; rd_en = re;
`ifdef RX_FIFO_OVF_FLAG_EN
    ovf_clr = oc;
`endif
    last_pop_vld = re && !empty;
    last_pop     = rd_data;
    @(posedge clk);
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() > 0);
`ifdef RX_FIFO_OVF_FLAG_EN
    if (we && q.size() == DEPTH) m_ovf = 1'b1;
    else if (oc)                 m_ovf = 1'b0;
`endif
    if (ra) void'(q.pop_front());
    if (wa) q.push_back({wer, ws, wd});
    #1;
    if (full) saw_full = 1'b1;
    check_model();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full),  0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_data"},  32'(rd_data), 0);
    chk({tag, "_start"}, 32'(rd_start), 0);
    chk({tag, "_error"}, 32'(rd_error), 0);
`ifdef RX_FIFO_OVF_FLAG_EN
    chk({tag, "_ovf"}, 32'(ovf), 0);
`endif
  endtask

  typedef struct {
    logic       we, ws, wer;
    logic [7:0] wd;
    logic       re;
    logic [6:0] c;
    logic       e, f;
    logic [7:0] d;
    logic       s, er;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Expected values are the outputs after the row's edge.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hAB, 1'b0, 7'd1, 1'b0, 1'b0, 8'hAB, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'hCD, 1'b0, 7'd2, 1'b0, 1'b0, 8'hAB, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 7'd3, 1'b0, 1'b0, 8'hAB, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'd2, 1'b0, 1'b0, 8'hCD, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'd1, 1'b0, 1'b0, 8'hEF, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 7'd1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    wr_en = 0; wr_start = 0; wr_error = 0; wr_data = 0; rd_en = 0;
`ifdef RX_FIFO_OVF_FLAG_EN
    ovf_clr = 0; m_ovf = 0;
`endif
    saw_full = 0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #2 check_reset_state("rst0");
    #9 n_rst = 1'b1;

    // Basic order and flags, simultaneous access when empty.
    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].ws, tbl[i].wer, tbl[i].wd, tbl[i].re, 1'b0);
      chk("tbl_count", 32'(count), 32'(tbl[i].c));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e));
      chk("tbl_full",  32'(full),  32'(tbl[i].f));
      chk("tbl_data",  32'(rd_data),  32'(tbl[i].d));
      chk("tbl_start", 32'(rd_start), 32'(tbl[i].s));
      chk("tbl_error", 32'(rd_error), 32'(tbl[i].er));
    end

    // Asynchronous reset in the middle of a frame.
    step(1, 1, 0, 8'h11, 0, 0);
    step(1, 0, 1, 8'h12, 0, 0);
    step(1, 0, 0, 8'h13, 0, 0);
    n_rst = 1'b0;
    #1 check_reset_state("rst_mid");
    q.delete();
`ifdef RX_FIFO_OVF_FLAG_EN
    m_ovf = 0;
`endif
    wr_en = 0;
    #2 n_rst = 1'b1;

    // Fill, overflow, simultaneous access when full, drain.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 64);
    step(1, 0, 0, 8'h99, 0, 0);
    chk("ovf_count", 32'(count), 64);
`ifdef RX_FIFO_OVF_FLAG_EN
    chk("ovf_set", 32'(ovf), 1);
`endif
    step(1, 0, 0, 8'h77, 1, 0);
    chk("full_rw_count", 32'(count), 63);
    chk("full_rw_pop", 32'(last_pop), 32'h00);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 0, 8'h00, 1, 0);
      chk("drain_data", 32'(last_pop), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(0, 0, 0, 8'h00, 0, 1);
`ifdef RX_FIFO_OVF_FLAG_EN
    chk("ovf_clr", 32'(ovf), 0);
`endif

    // Simultaneous access at count 5.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h20 + i), 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 8'(8'h25 + k), 1, 0);
      chk("rw5_count", 32'(count), 5);
      chk("rw5_pop", 32'(last_pop), 32'(8'h20 + k));
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 8'h00, 1, 0);
      chk("rw5_drain", 32'(last_pop), 32'(8'h24 + k));
    end
    chk("rw5_empty", 32'(empty), 1);

    // Streaming wrap-around with rd_en held high.
    saw_full = 0;
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 8'(i), 1, 0);
      if (i > 0) chk("stream_pop", 32'(last_pop), 32'(i - 1));
    end
    step(0, 0, 0, 8'h00, 1, 0);
    chk("stream_last", 32'(last_pop), 32'd199);
    chk("stream_empty", 32'(empty), 1);
    chk("stream_nofull", 32'(saw_full), 0);

    // Receiver back-pressure: three back-to-back writes at 63.
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 8'(i + 8'h40), 0, 0);
    chk("bp63_count", 32'(count), 63);
    chk("bp63_full", 32'(full), 0);
    step(1, 0, 0, 8'h10, 0, 0);
    chk("bp_full", 32'(full), 1);
    step(1, 0, 0, 8'h11, 0, 0);
    chk("bp_count1", 32'(count), 64);
    step(1, 0, 0, 8'h12, 0, 1);
    chk("bp_count2", 32'(count), 64);
`ifdef RX_FIFO_OVF_FLAG_EN
    chk("ovf_set_wins", 32'(ovf), 1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 8'h00, 1, 0);
      chk("bp_drain", 32'(last_pop), (i < DEPTH - 1) ? 32'(i + 8'h40) : 32'h10);
    end
    chk("bp_empty", 32'(empty), 1);
    step(0, 0, 0, 8'h00, 0, 1);

    // Randomized traffic with varying write/read pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 2 == 0) ? int'($urandom_range(60, 95)) : int'($urandom_range(5, 40));
      pr = (ph % 2 == 0) ? int'($urandom_range(5, 40))  : int'($urandom_range(60, 95));
      for (int c = 0; c < 400; c++) begin
        step(1'($urandom_range(99) < pw), 1'($urandom), 1'($urandom),
             8'($urandom), 1'($urandom_range(99) < pr), 1'($urandom_range(15) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-path byte buffer between the MAC receiver and the USB-side packetizer. Stores each byte written by the MAC receiver together with its frame-start and error flags, and back-pressures the receiver through `full`. Presents the oldest entry to the USB side in first-word-fall-through form.

## Interface
- `DEPTH`, 64, number of entries; power of two, at least 4.
- `ADDR_W`, $clog2(DEPTH), pointer width; derived, not overridden.

- `clk`  in  1  system clock; all logic is rising-edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe from the MAC receiver.
- `wr_start`  in  1  marks the first byte of a frame; sampled with `wr_en`.
- `wr_error`  in  1  marks a byte received with an error; sampled with `wr_en`.
- `wr_data`  in  8  byte to store.
- `full`  out  1  buffer holds DEPTH entries; drives the receiver's `fifo_full`.
- `rd_en`  in  1  pop strobe from the consumer.
- `rd_data`  out  8  head byte.
- `rd_start`  out  1  head entry's start flag.
- `rd_error`  out  1  head entry's error flag.
- `empty`  out  1  buffer holds no entries.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky overflow flag; present only with `RX_FIFO_OVF_FLAG_EN`.
- `ovf_clr`  in  1  clears `ovf`; present only with `RX_FIFO_OVF_FLAG_EN`.

## Operation
- **Storage**: DEPTH x 10-bit memory holding {error, start, data}. Memory contents are not reset.
- **Pointers**: `wptr` and `rptr` are ADDR_W bits wide and wrap modulo DEPTH. `count` is held in its own register.
- **Write acceptance**: a write is accepted iff `wr_en && !full`. On acceptance, mem[`wptr`] <= {`wr_error`, `wr_start`, `wr_data`} and `wptr` increments.
- **Read acceptance**: a read is accepted iff `rd_en && !empty`. On acceptance, `rptr` increments.
- **Rejected strobes**:
  - `wr_en` while `full` drops the byte silently. Pointers and `count` are unchanged.
  - `rd_en` while `empty` is ignored.
- **Count update**: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- **Flags**: `full` = (`count` == DEPTH); `empty` = (`count` == 0). Both are registered alongside `count`.
- **Head outputs**: `rd_data`, `rd_start` and `rd_error` equal mem[`rptr`] while `!empty`. They are forced to 0 while `empty`.
- **Flags pass through unchanged**: no frame-level interpretation. `wr_start` and `wr_error` are stored exactly as presented.
- **Reset values**, asynchronous on `n_rst` low, including mid-frame:
  - `wptr` = 0, `rptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `rd_data` = 0, `rd_start` = 0, `rd_error` = 0, `ovf` = 0.
  - Partial frames are discarded.

## Timing
- **Write-to-read latency**: a write accepted at edge N makes `empty` = 0 and the byte visible on `rd_*` after edge N, i.e. in cycle N+1. A read of it is accepted at edge N+1 at the earliest.
- **Read**: fall-through. Data is valid in the same cycle `rd_en` is asserted. The next entry appears after the popping edge.
- **`full` timing**: `full` rises after the edge that accepts the DEPTH-th entry. The receiver sees it in the following cycle, so any byte it presents in that cycle is dropped.
- **Simultaneous write and read**:
  - When empty: only the write is accepted; `count` = 1 next cycle.
  - When full: only the read is accepted; the write is dropped and `count` = DEPTH-1 next cycle.
  - Otherwise: both are accepted and `count` is unchanged.
- **Wrap-around**: pointers roll from DEPTH-1 to 0 with no bubble.

## Configuration
- **`RX_FIFO_OVF_FLAG_EN` defined**: adds the `ovf` and `ovf_clr` ports.
  - `ovf` sets on the edge where `wr_en && full`.
  - `ovf` clears on the edge where `ovf_clr` = 1.
  - If both occur on the same edge, set wins.
  - `ovf` holds its value otherwise.
- **`RX_FIFO_OVF_FLAG_EN` undefined**: `ovf` and `ovf_clr` do not exist. Overflowing bytes are dropped silently with no other behavioural difference.

## Test plan
- **Reset**: assert `n_rst` = 0 mid-stream -> immediately `empty` = 1, `full` = 0, `count` = 0, `rd_data` = 0x00, `rd_start` = 0, `rd_error` = 0.
- **Basic order and flags**: write 0xAB with `wr_start` = 1, then 0xCD, then 0xEF with `wr_error` = 1. Expect `count` = 3. Then pop three times -> {0xAB, start 1, error 0}, {0xCD, 0, 0}, {0xEF, 0, 1}, after which `empty` = 1.
- **Fill and overflow**: write 0x00..0x3F (DEPTH = 64) -> `full` = 1 and `count` = 64. Then write 0x99 -> dropped, `count` = 64, and with the macro `ovf` = 1. Drain -> 0x00..0x3F in order with no 0x99. Pulse `ovf_clr` -> `ovf` = 0.
- **Simultaneous read/write**:
  - At `count` = 5, assert `wr_en` + `rd_en` for 4 cycles -> `count` stays 5 and output order is preserved.
  - At `count` = 64, assert `wr_en` + `rd_en` -> `count` = 63 and the write is dropped.
  - At `count` = 0, assert `wr_en` + `rd_en` -> `count` = 1.
- **Streaming wrap-around**: 200 bytes (incrementing 0x00..0xC7) written with `rd_en` held high -> read sequence identical, `full` never asserted, `empty` = 1 after the last pop.
- **Receiver back-pressure**: fill to 63, then write 3 back-to-back bytes 0x10, 0x11, 0x12 -> only 0x10 is stored, `full` = 1, and 0x11 and 0x12 are dropped.
